// File: rtl/hazard_pkg.sv
// Shared encodings for the D-stage hazard unit.
//   POS_*  : stage position of an in-flight writer (00 = not tracked)
//   MD_*   : HI/LO unit operation class seen in D
//   FWD_*  : forward-source selects, identical to the datapath mux encoding.
//            Equal to POS_* so a pending entry's position is its select.
package hazard_pkg;
  localparam logic [1:0] POS_NONE = 2'b00;
  localparam logic [1:0] POS_E    = 2'b01;
  localparam logic [1:0] POS_M    = 2'b10;
  localparam logic [1:0] POS_W    = 2'b11;

  localparam logic [1:0] MD_NONE  = 2'b00;
  localparam logic [1:0] MD_MUL   = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_ACC   = 2'b11;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_E    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_W    = 2'b11;
endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: youngest in-flight writer of a single GPR.
// Ports:
//   clk, reset    : clock, synchronous active-low reset
//   ins, ins_tnew : insert a new writer entering E with the given Tnew
//   pend, pos, tnew : entry state (pos uses POS_* encoding)
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ins,
  input  logic [TW-1:0] ins_tnew,
  output logic          pend,
  output logic [1:0]    pos,
  output logic [TW-1:0] tnew
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend <= 1'b0;
      pos  <= POS_NONE;
      tnew <= '0;
    end else if (ins) begin
      // youngest writer wins over advance/retire of an older one
      pend <= 1'b1;
      pos  <= POS_E;
      tnew <= ins_tnew;
    end else if (pend) begin
      if (pos == POS_W) begin
        // value lands in the RF at this edge
        pend <= 1'b0;
        pos  <= POS_NONE;
        tnew <= '0;
      end else begin
        pos <= pos + 2'd1;
        if (tnew != '0) tnew <= tnew - TW'(1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit driven by a per-register writer scoreboard.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   d_valid                    : D holds a real instruction
//   d_rs/d_rt, d_*_tuse        : sources and their Tuse (3 = unused)
//   d_wr_en/addr/tnew          : destination write and its Tnew entering E
//   d_md_op                    : HI/LO op class (MD_*)
//   stall                      : hold PC/D, bubble into E
//   rs_fwd_sel, rt_fwd_sel     : D-stage forward source (FWD_*)
//   md_busy                    : HI/LO countdown running
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_rs_tuse,
  input  logic [TW-1:0] d_rt_tuse,
  input  logic          d_wr_en,
  input  logic [AW-1:0] d_wr_addr,
  input  logic [TW-1:0] d_wr_tnew,
  input  logic [1:0]    d_md_op,
  output logic          stall,
  output logic [1:0]    rs_fwd_sel,
  output logic [1:0]    rt_fwd_sel,
  output logic          md_busy
);

  localparam int CW = $clog2(DIV_CYC + 1);

  logic [NREG-1:0]         pend;
  logic [NREG-1:0][1:0]    pos;
  logic [NREG-1:0][TW-1:0] tnew;
  logic [CW-1:0]           cnt;
  logic                    issue;
  logic                    rs_pend, rt_pend, rs_haz, rt_haz, md_haz;

  assign issue = d_valid & ~stall;

  // $0 never has a writer
  assign pend[0] = 1'b0;
  assign pos[0]  = POS_NONE;
  assign tnew[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    hazard_sb_entry #(.TW(TW)) u_ent (
      .clk      (clk),
      .reset    (reset),
      .ins      (issue & d_wr_en & (d_wr_addr == AW'(r))),
      .ins_tnew (d_wr_tnew),
      .pend     (pend[r]),
      .pos      (pos[r]),
      .tnew     (tnew[r])
    );
  end

  // Lookups use pre-edge state; the D instruction never sees itself.
  always_comb begin
    rs_pend = (d_rs != '0) & pend[d_rs];
    rt_pend = (d_rt != '0) & pend[d_rt];
    rs_haz  = d_valid & rs_pend & (d_rs_tuse < tnew[d_rs]);
    rt_haz  = d_valid & rt_pend & (d_rt_tuse < tnew[d_rt]);
    md_haz  = d_valid & (d_md_op != MD_NONE) & md_busy;
    stall   = rs_haz | rt_haz | md_haz;
    // pending but not ready: later-stage muxes pick it up
    rs_fwd_sel = (rs_pend && tnew[d_rs] == '0) ? pos[d_rs] : FWD_RF;
    rt_fwd_sel = (rt_pend && tnew[d_rt] == '0) ? pos[d_rt] : FWD_RF;
  end

  assign md_busy = (cnt != '0);

  always_ff @(posedge clk) begin
    if (!reset)                          cnt <= '0;
    else if (issue && d_md_op == MD_MUL) cnt <= CW'(MULT_CYC);
    else if (issue && d_md_op == MD_DIV) cnt <= CW'(DIV_CYC);
    else if (cnt != '0)                  cnt <= cnt - CW'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wr_addr;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_wr_tnew, d_md_op;
  logic       d_wr_en;
  logic       stall, md_busy;
  logic [1:0] rs_fwd_sel, rt_fwd_sel;

  int tests = 0;
  int fails = 0;

  hazard_scoreboard #(.NREG(32), .TW(2), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_wr_tnew(d_wr_tnew),
    .d_md_op(d_md_op), .stall(stall), .rs_fwd_sel(rs_fwd_sel),
    .rt_fwd_sel(rt_fwd_sel), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, vld;
    logic [4:0] rs;  logic [1:0] rsu;
    logic [4:0] rt;  logic [1:0] rtu;
    logic       we;  logic [4:0] wa;  logic [1:0] wt;
    logic [1:0] md;
    logic       es;  logic [1:0] ers, ert;  logic emb;
  } vec_t;

  function automatic vec_t mk(string n, logic rst, logic vld,
                              logic [4:0] rs, logic [1:0] rsu,
                              logic [4:0] rt, logic [1:0] rtu,
                              logic we, logic [4:0] wa, logic [1:0] wt,
                              logic [1:0] md, logic es, logic [1:0] ers,
                              logic [1:0] ert, logic emb);
    vec_t v;
    v.name = n; v.rst = rst; v.vld = vld; v.rs = rs; v.rsu = rsu;
    v.rt = rt; v.rtu = rtu; v.we = we; v.wa = wa; v.wt = wt; v.md = md;
    v.es = es; v.ers = ers; v.ert = ert; v.emb = emb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; d_valid = v.vld; d_rs = v.rs; d_rs_tuse = v.rsu;
    d_rt = v.rt; d_rt_tuse = v.rtu; d_wr_en = v.we; d_wr_addr = v.wa;
    d_wr_tnew = v.wt; d_md_op = v.md;
  endtask

  task automatic cmp(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  task automatic check_vec(input string n, input vec_t v);
    cmp({n, " stall"},   int'(stall),      int'(v.es));
    cmp({n, " rs_sel"},  int'(rs_fwd_sel), int'(v.ers));
    cmp({n, " rt_sel"},  int'(rt_fwd_sel), int'(v.ert));
    cmp({n, " md_busy"}, int'(md_busy),    int'(v.emb));
  endtask

  // Issue an HI/LO op, then hold mflo in D and count stall cycles.
  task automatic md_seq(input string n, input logic [1:0] op, input int exp_n);
    int cyc;
    drive(mk(n, 1, 1, 0, 3, 0, 3, 0, 0, 0, op, 0, 0, 0, 0));
    #2; cmp({n, " issue stall"}, int'(stall), 0);
    @(posedge clk); #1;
    drive(mk(n, 1, 1, 0, 3, 0, 3, 0, 0, 0, MD_ACC, 0, 0, 0, 0));
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      #2;
      if (!stall) break;
      cmp({n, " busy during stall"}, int'(md_busy), 1);
      cyc++;
      @(posedge clk); #1;
    end
    cmp({n, " stall cycles"}, cyc, exp_n);
    cmp({n, " busy after release"}, int'(md_busy), 0);
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];

  initial begin
    // name rst vld rs rsu rt rtu we wa wt md | stall rs_sel rt_sel busy
    tbl.push_back(mk("rst_state", 1, 0, 0, 3, 0, 3, 0, 0, 0, MD_NONE, 0, 0, 0, 0));
    // load-use
    tbl.push_back(mk("lu_lw8",    1, 1, 1, 1, 0, 3, 1, 8, 2, MD_NONE, 0, 0, 0, 0));
    tbl.push_back(mk("lu_stall",  1, 1, 8, 1, 0, 3, 1,11, 1, MD_NONE, 1, 0, 0, 0));
    tbl.push_back(mk("lu_go",     1, 1, 8, 1, 0, 3, 1,11, 1, MD_NONE, 0, 0, 0, 0));
    tbl.push_back(mk("lu_w_e",    1, 1, 8, 0,11, 0, 0, 0, 0, MD_NONE, 1, 3, 0, 0));
    tbl.push_back(mk("lu_m",      1, 1, 8, 0,11, 0, 0, 0, 0, MD_NONE, 0, 0, 2, 0));
    // ALU -> branch
    tbl.push_back(mk("br_add3",   1, 1, 0, 3, 0, 3, 1, 3, 1, MD_NONE, 0, 0, 0, 0));
    tbl.push_back(mk("br_stall",  1, 1, 3, 0, 0, 3, 0, 0, 0, MD_NONE, 1, 0, 0, 0));
    tbl.push_back(mk("br_fwd_m",  1, 1, 3, 0, 0, 3, 0, 0, 0, MD_NONE, 0, 2, 0, 0));
    tbl.push_back(mk("br_add4",   1, 1, 0, 3, 0, 3, 1, 4, 1, MD_NONE, 0, 0, 0, 0));
    tbl.push_back(mk("br_tuse1",  1, 1, 4, 1, 3, 0, 0, 0, 0, MD_NONE, 0, 0, 0, 0));
    // override: lw $5 then addu $5
    tbl.push_back(mk("ov_lw5",    1, 1, 0, 3, 0, 3, 1, 5, 2, MD_NONE, 0, 0, 0, 0));
    tbl.push_back(mk("ov_add5",   1, 1, 0, 3, 0, 3, 1, 5, 1, MD_NONE, 0, 0, 0, 0));
    tbl.push_back(mk("ov_rd_e",   1, 1, 5, 1, 0, 3, 0, 0, 0, MD_NONE, 0, 0, 0, 0));
    tbl.push_back(mk("ov_rd_m",   1, 1, 5, 0, 0, 3, 0, 0, 0, MD_NONE, 0, 2, 0, 0));
    tbl.push_back(mk("ov_rd_w",   1, 1, 0, 3, 5, 0, 0, 0, 0, MD_NONE, 0, 0, 3, 0));
    tbl.push_back(mk("ov_rd_rf",  1, 1, 5, 0, 5, 0, 0, 0, 0, MD_NONE, 0, 0, 0, 0));
    // $0 and unused sources
    tbl.push_back(mk("z_wr0",     1, 1, 0, 3, 0, 3, 1, 0, 2, MD_NONE, 0, 0, 0, 0));
    tbl.push_back(mk("z_rd0",     1, 1, 0, 0, 0, 0, 0, 0, 0, MD_NONE, 0, 0, 0, 0));
    tbl.push_back(mk("z_lw10",    1, 1, 0, 3, 0, 3, 1,10, 2, MD_NONE, 0, 0, 0, 0));
    tbl.push_back(mk("z_tuse3",   1, 1,10, 3,10, 3, 0, 0, 0, MD_NONE, 0, 0, 0, 0));
    tbl.push_back(mk("z_novalid", 1, 0,10, 0, 0, 3, 0, 0, 0, MD_NONE, 0, 0, 0, 0));
    tbl.push_back(mk("z_nv_w",    1, 0,10, 0, 0, 3, 1,12, 1, MD_NONE, 0, 3, 0, 0));
    tbl.push_back(mk("z_nv_noins",1, 1,12, 0, 0, 3, 0, 0, 0, MD_NONE, 0, 0, 0, 0));
    // HI/LO access never loads the counter
    tbl.push_back(mk("md_acc",    1, 1, 0, 3, 0, 3, 0, 0, 0, MD_ACC,  0, 0, 0, 0));
    tbl.push_back(mk("md_acc_nl", 1, 1, 0, 3, 0, 3, 0, 0, 0, MD_ACC,  0, 0, 0, 0));

    reset = 1'b0; d_valid = 0; d_rs = 0; d_rt = 0; d_rs_tuse = 3; d_rt_tuse = 3;
    d_wr_en = 0; d_wr_addr = 0; d_wr_tnew = 0; d_md_op = MD_NONE;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #2;
      check_vec($sformatf("%s[%0d]", tbl[i].name, i), tbl[i]);
      @(posedge clk); #1;
    end

    md_seq("div", MD_DIV, DIV_CYC);
    md_seq("mult", MD_MUL, MULT_CYC);

    // reset in the middle of a load and a divide
    drive(mk("rs_lw9", 1, 1, 0, 3, 0, 3, 1, 9, 2, MD_NONE, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk("rs_div", 1, 1, 0, 3, 0, 3, 0, 0, 0, MD_DIV, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk("rs_pre", 0, 1, 9, 0, 9, 0, 0, 0, 0, MD_ACC, 0, 0, 0, 0));
    #2;
    cmp("rst_mid pre stall", int'(stall), 1);
    cmp("rst_mid pre busy", int'(md_busy), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    cmp("rst_mid stall", int'(stall), 0);
    cmp("rst_mid busy", int'(md_busy), 0);
    cmp("rst_mid rs_sel", int'(rs_fwd_sel), 0);
    cmp("rst_mid rt_sel", int'(rt_fwd_sel), 0);
    @(posedge clk); #1;
    cmp("rst_mid next stall", int'(stall), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
